// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I (+ optional RV32M) decode stage between
// fetch and execute, with valid/ready handshake, one-entry skid buffer and flush.
module rv_decode_stage #(
    parameter int unsigned PC_W = 32,
    parameter bit          EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic            out_rd_we,
    output logic [9:0]      out_f7f3,
    output logic            out_illegal
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [31:0]      imm;
        logic             rd_we;
        logic [9:0]       f7f3;
        logic             illegal;
    } dec_t;

    dec_t       dec_c;
    dec_t       main_q, main_d;
    dec_t       skid_q, skid_d;
    logic       main_valid_q, main_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       accept;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};

    // Decode the incoming word into operation, register fields and immediate.
    always_comb begin
        logic use_rd, use_rs1, use_rs2;
        logic [OP_W-1:0] op;
        logic [31:0]     imm;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        op      = '0;
        imm     = '0;
        case (opcode)
            7'b0110111: begin op = 6'd1; use_rd = 1'b1; imm = imm_u; end
            7'b0010111: begin op = 6'd2; use_rd = 1'b1; imm = imm_u; end
            7'b1101111: begin op = 6'd3; use_rd = 1'b1; imm = imm_j; end
            7'b1100111: begin
                op = (f3 == 3'b000) ? 6'd4 : 6'd0;
                use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  op = 6'd5;
                    3'b001:  op = 6'd6;
                    3'b100:  op = 6'd7;
                    3'b101:  op = 6'd8;
                    3'b110:  op = 6'd9;
                    3'b111:  op = 6'd10;
                    default: op = 6'd0;
                endcase
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
            end
            7'b0000011: begin
                case (f3)
                    3'b000:  op = 6'd11;
                    3'b001:  op = 6'd12;
                    3'b010:  op = 6'd13;
                    3'b100:  op = 6'd14;
                    3'b101:  op = 6'd15;
                    default: op = 6'd0;
                endcase
                use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
            end
            7'b0100011: begin
                case (f3)
                    3'b000:  op = 6'd16;
                    3'b001:  op = 6'd17;
                    3'b010:  op = 6'd18;
                    default: op = 6'd0;
                endcase
                use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
            end
            7'b0010011: begin
                case (f3)
                    3'b000:  op = 6'd19;
                    3'b010:  op = 6'd20;
                    3'b011:  op = 6'd21;
                    3'b100:  op = 6'd22;
                    3'b110:  op = 6'd23;
                    3'b111:  op = 6'd24;
                    3'b001:  op = (f7 == 7'b0000000) ? 6'd25 : 6'd0;
                    default: op = (f7 == 7'b0000000) ? 6'd26 :
                                  (f7 == 7'b0100000) ? 6'd27 : 6'd0;
                endcase
                use_rd = 1'b1; use_rs1 = 1'b1; imm = imm_i;
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  op = 6'd28;
                        3'b001:  op = 6'd30;
                        3'b010:  op = 6'd31;
                        3'b011:  op = 6'd32;
                        3'b100:  op = 6'd33;
                        3'b101:  op = 6'd34;
                        3'b110:  op = 6'd36;
                        default: op = 6'd37;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    op = (f3 == 3'b000) ? 6'd29 : (f3 == 3'b101) ? 6'd35 : 6'd0;
                end else if (f7 == 7'b0000001 && EN_M) begin
                    op = 6'd39 + 6'(f3);
                end
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b1110011: op = (in_instr == 32'h0000_0073) ? 6'd38 : 6'd0;
            default:    op = '0;
        endcase

        // Illegal encodings carry no register fields or immediate.
        dec_c.pc      = in_pc;
        dec_c.op      = op;
        dec_c.illegal = (op == '0);
        dec_c.f7f3    = {f7, f3};
        dec_c.rd      = (use_rd  && !dec_c.illegal) ? in_instr[11:7]  : '0;
        dec_c.rs1     = (use_rs1 && !dec_c.illegal) ? in_instr[19:15] : '0;
        dec_c.rs2     = (use_rs2 && !dec_c.illegal) ? in_instr[24:20] : '0;
        dec_c.imm     = dec_c.illegal ? '0 : imm;
        dec_c.rd_we   = (dec_c.rd != '0);
    end

    assign accept = in_valid & in_ready_q & ~flush;

    // Main/skid occupancy: drain refills main from skid first, stall parks into skid.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_c;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_op      = main_q.op;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_q.imm;
    assign out_rd_we   = main_q.rd_we;
    assign out_f7f3    = main_q.f7f3;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vector table plus handshake,
// skid, flush and async-reset sequences; EN_M=0 and EN_M=1 instances side by side.
module tb_rv_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_rd_we, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [5:0]  out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [9:0]  out_f7f3;

    logic        m_in_ready, m_out_valid, m_out_rd_we, m_out_illegal;
    logic [31:0] m_out_pc, m_out_imm;
    logic [5:0]  m_out_op;
    logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
    logic [9:0]  m_out_f7f3;

    int checks = 0;
    int errors = 0;

    rv_decode_stage #(.PC_W(32), .EN_M(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_rd_we(out_rd_we), .out_f7f3(out_f7f3),
        .out_illegal(out_illegal)
    );

    rv_decode_stage #(.PC_W(32), .EN_M(1'b1)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc),
        .out_op(m_out_op), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
        .out_imm(m_out_imm), .out_rd_we(m_out_rd_we), .out_f7f3(m_out_f7f3),
        .out_illegal(m_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        we;
        logic        ill;
        logic        m_diff;
    } vec_t;

    localparam int unsigned NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        vecs[0]  = '{32'h002081B3, 6'd28, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b1, 1'b0, 1'b0}; // add x3,x1,x2
        vecs[1]  = '{32'hFFF00093, 6'd19, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}; // addi x1,x0,-1
        vecs[2]  = '{32'hFE208EE3, 6'd5,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0}; // beq x1,x2,-4
        vecs[3]  = '{32'h027302B3, 6'd0,  5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b1}; // mul x5,x6,x7
        vecs[4]  = '{32'h00000073, 6'd38, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0}; // ecall
        vecs[5]  = '{32'h00100073, 6'd0,  5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0}; // ebreak
        vecs[6]  = '{32'h00000012, 6'd0,  5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0}; // nop, [1:0]=10
        vecs[7]  = '{32'h123450B7, 6'd1,  5'd1, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b0, 1'b0}; // lui x1
        vecs[8]  = '{32'h0020A423, 6'd18, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b0, 1'b0, 1'b0}; // sw x2,8(x1)
        vecs[9]  = '{32'h010000EF, 6'd3,  5'd1, 5'd0, 5'd0, 32'h0000_0010, 1'b1, 1'b0, 1'b0}; // jal x1,16
        vecs[10] = '{32'h40335293, 6'd27, 5'd5, 5'd6, 5'd0, 32'h0000_0403, 1'b1, 1'b0, 1'b0}; // srai x5,x6,3
        vecs[11] = '{32'h40331293, 6'd0,  5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b0}; // slli bad f7
        vecs[12] = '{32'h402081B3, 6'd29, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b1, 1'b0, 1'b0}; // sub x3,x1,x2
        vecs[13] = '{32'h0040A003, 6'd13, 5'd0, 5'd1, 5'd0, 32'h0000_0004, 1'b0, 1'b0, 1'b0}; // lw x0,4(x1)

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid_after", 32'(out_valid), 32'd0);
        chk("reset_out_op", 32'(out_op), 32'd0);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);

        // Back-to-back decode at full throughput.
        for (int i = 0; i < int'(NV); i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h1000 + 32'(4 * i);
            step();
            w = vecs[i].instr;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
            chk($sformatf("v%0d_op", i), 32'(out_op), 32'(vecs[i].op));
            chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_rs1", i), 32'(out_rs1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(out_rs2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d_we", i), 32'(out_rd_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d_f7f3", i), 32'(out_f7f3), 32'({w[31:25], w[14:12]}));
            if (vecs[i].m_diff) begin
                chk($sformatf("v%0d_m_op", i), 32'(m_out_op), 32'd39);
                chk($sformatf("v%0d_m_rd", i), 32'(m_out_rd), 32'd5);
                chk($sformatf("v%0d_m_rs2", i), 32'(m_out_rs2), 32'd7);
                chk($sformatf("v%0d_m_we", i), 32'(m_out_rd_we), 32'd1);
                chk($sformatf("v%0d_m_illegal", i), 32'(m_out_illegal), 32'd0);
            end else begin
                chk($sformatf("v%0d_m_op", i), 32'(m_out_op), 32'(vecs[i].op));
                chk($sformatf("v%0d_m_imm", i), m_out_imm, vecs[i].imm);
            end
        end
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Stall: three offered back-to-back, two taken, then in-order release.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h2000;
        step();
        chk("stall_a_in_ready", 32'(in_ready), 32'd1);
        in_instr = 32'hFFF00093; in_pc = 32'h2004;
        step();
        chk("stall_b_in_ready", 32'(in_ready), 32'd0);
        in_instr = 32'hFE208EE3; in_pc = 32'h2008;
        step();
        chk("stall_c_in_ready", 32'(in_ready), 32'd0);
        chk("stall_hold_op", 32'(out_op), 32'd28);
        chk("stall_hold_pc", out_pc, 32'h2000);
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("rel_b_op", 32'(out_op), 32'd19);
        chk("rel_b_pc", out_pc, 32'h2004);
        chk("rel_b_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("rel_c_op", 32'(out_op), 32'd5);
        chk("rel_c_pc", out_pc, 32'h2008);
        in_valid = 1'b0;
        step();
        chk("rel_empty", 32'(out_valid), 32'd0);

        // Flush with both entries held and a new instruction offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h3000;
        step();
        in_instr = 32'hFFF00093; in_pc = 32'h3004;
        step();
        chk("flush_full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h3008;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("flush_quiet%0d", k), 32'(out_valid), 32'd0);
        end

        // Async reset mid-stream drops out_valid without a clock edge.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h4000;
        step();
        in_valid = 1'b0;
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_op", 32'(out_op), 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("arst_after_valid", 32'(out_valid), 32'd0);
        chk("arst_after_in_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, parametrised RV32I instruction-decode pipeline stage with a valid/ready handshake, a one-entry skid buffer, flush, and optional RV32M decode. It sits between fetch and execute. It replaces the flat combinational per-instruction flag decoder with an encoded opcode, extracted register fields and a sign-extended immediate, all registered with one cycle of latency. Back-pressure from execute is absorbed without bubbles.

## Interface
- PC_W, 32, width of the PC carried alongside each instruction
- EN_M, 0, 1 enables decode of the RV32M MUL/DIV group; 0 reports those encodings as illegal
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- in_instr  in  32  raw instruction word
- in_pc  in  PC_W  PC of in_instr
- flush  in  1  synchronous kill of all held and incoming instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts; transfer when out_valid & out_ready
- out_pc  out  PC_W  PC of the decoded instruction
- out_op  out  6  encoded operation (see Operation)
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when the field is unused by the format
- out_imm  out  32  sign-extended immediate; 0 for R-type
- out_rd_we  out  1  writes rd
- out_f7f3  out  10  {instr[31:25], instr[14:12]}
- out_illegal  out  1  unrecognised encoding (out_op = 0)

## Operation
- out_op encoding: 0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BEQ, 6 BNE, 7 BLT, 8 BGE, 9 BLTU, 10 BGEU, 11 LB, 12 LH, 13 LW, 14 LBU, 15 LHU, 16 SB, 17 SH, 18 SW, 19 ADDI, 20 SLTI, 21 SLTIU, 22 XORI, 23 ORI, 24 ANDI, 25 SLLI, 26 SRLI, 27 SRAI, 28 ADD, 29 SUB, 30 SLL, 31 SLT, 32 SLTU, 33 XOR, 34 SRL, 35 SRA, 36 OR, 37 AND, 38 ECALL, 39 MUL, 40 MULH, 41 MULHSU, 42 MULHU, 43 DIV, 44 DIVU, 45 REM, 46 REMU.
- Illegal conditions:
  - instr[1:0] != 2'b11, or unknown opcode/funct3.
  - R-type funct7 other than 0000000, or 0100000 for SUB/SRA only, or 0000001 only when EN_M = 1.
  - Shift-immediate funct7 other than 0000000, or 0100000 for SRAI.
  - ECALL other than exactly 0x00000073.
- Immediates, sign-extended from instr[31]:
  - I-type: loads, OP-IMM, JALR.
  - S-type: stores.
  - B-type: branches, bit 0 = 0.
  - J-type: JAL, bit 0 = 0.
  - U-type: {instr[31:12], 12'b0}.
- Register fields:
  - rs1 is valid for all formats except U, J and ECALL.
  - rs2 is valid for R, S and B formats only.
  - rd is valid for R, I, U and J formats.
- out_rd_we = 1 only when the format writes rd and rd != 0. It is always 0 for illegal instructions.
- Storage: a main output register plus one skid register. in_ready = !skid_full (registered).
  - Accept while the main register is empty or draining goes straight to main.
  - Accept while main is stalled (out_valid & !out_ready) goes to skid.
  - When main drains, skid moves to main the same cycle.

## Timing
- Latency: an instruction accepted at edge N appears on out_* after edge N; valid from cycle N+1.
- Throughput: 1 instruction/cycle when out_ready = 1.
- Reset (async, rst_n = 0): out_valid = 0, in_ready = 1 on the first edge after release, skid empty, all data outputs 0.
- out_* must hold stable while out_valid & !out_ready.
- flush = 1: main and skid are cleared at the edge (out_valid = 0 the next cycle). An in_valid presented in the same cycle is dropped, and in_ready returns to 1 the next cycle.
- Simultaneous accept and drain with skid empty: the new instruction loads main and out_valid stays 1.
- Skid full: in_ready = 0; any in_valid is ignored until the next drain.
- rst_n asserted mid-stream: all held instructions are discarded immediately, without waiting for clk.

## Test plan
- 0x002081B3 (add x3,x1,x2), out_ready = 1 -> next cycle out_op = 28, rd = 3, rs1 = 1, rs2 = 2, out_rd_we = 1, imm = 0.
- 0xFFF00093 (addi x1,x0,-1) -> out_op = 19, out_imm = 0xFFFFFFFF, rs2 = 0. Then 0xFE208EE3 (beq x1,x2,-4) -> out_op = 5, out_imm = 0xFFFFFFFC, out_rd_we = 0.
- 0x027302B3 (mul x5,x6,x7) -> with EN_M = 0: out_op = 0, out_illegal = 1, out_rd_we = 0. With EN_M = 1: out_op = 39, rd = 5.
- out_ready = 0, push 3 back-to-back instructions -> 2 accepted, in_ready = 0 from the cycle after the 2nd accept. Release out_ready -> all in order, no loss or duplication.
- Full pipeline (both entries held) plus flush with in_valid = 1 -> out_valid = 0 next cycle, nothing emitted afterwards, in_ready = 1.
- 0x00000073 -> out_op = 38. 0x00100073 -> illegal. 0x00000013 with instr[1:0] forced to 2'b10 -> illegal. rst_n pulsed low mid-stream -> out_valid drops at once.
